// File: rtl/aes_pkg.sv
// aes_pkg: FSM encoding, GF(2^8) constant, and xtime-based multiply helpers for the inverse AES round.
package aes_pkg;
  typedef enum logic [1:0] {IDLE, S_MIX, S_SHIFT} state_e;
  localparam logic [7:0] GF_POLY = 8'h1B;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction
  function automatic logic [7:0] x9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction
  function automatic logic [7:0] xb(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction
  function automatic logic [7:0] xd(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction
  function automatic logic [7:0] xe(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction
  // Row r of the column-major state rotates right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction
endpackage

// File: rtl/aes_inv_mixcol.sv
// aes_inv_mixcol: combinational InvMixColumns on one 32-bit column (row 0 in the top byte).
module aes_inv_mixcol
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);
  logic [7:0] a0, a1, a2, a3;
  assign {a0, a1, a2, a3} = col_i;
  assign col_o = {xe(a0) ^ xb(a1) ^ xd(a2) ^ x9(a3),
                  x9(a0) ^ xe(a1) ^ xb(a2) ^ xd(a3),
                  xd(a0) ^ x9(a1) ^ xe(a2) ^ xb(a3),
                  xb(a0) ^ xd(a1) ^ x9(a2) ^ xe(a3)};
endmodule

// File: rtl/aes_inv.sv
// aes_inv: one inverse AES round (InvMixColumns, InvShiftRows, AddRoundKey), one stage per clock.
// Defining AES_INV_LAST_ROUND_EN adds a 'last' input that bypasses InvMixColumns.
module aes_inv
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
`ifdef AES_INV_LAST_ROUND_EN
  input  logic         last,
`endif
  input  logic [127:0] matrix1,
  input  logic [127:0] matrix2,
  output logic [1:0]   count,
  output logic [127:0] matrix3,
  output logic         busy,
  output logic         done
);
  state_e       state_q, state_d;
  logic [1:0]   count_q, count_d;
  logic [127:0] matrix3_q, matrix3_d, key_q, key_d, mix, load;
  logic         busy_q, busy_d, done_q, done_d;
  for (genvar c = 0; c < 4; c++) begin : g_col
    aes_inv_mixcol u_mix (.col_i(matrix1[127-32*c -: 32]), .col_o(mix[127-32*c -: 32]));
  end
`ifdef AES_INV_LAST_ROUND_EN
  assign load = last ? matrix1 : mix;
`else
  assign load = mix;
`endif
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    matrix3_d = matrix3_q;
    key_d     = key_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: if (valid) begin
        key_d     = matrix2;
        matrix3_d = load;
        count_d   = 2'd1;
        busy_d    = 1'b1;
        state_d   = S_MIX;
      end
      S_MIX: begin
        matrix3_d = inv_shift_rows(matrix3_q);
        count_d   = 2'd2;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        matrix3_d = matrix3_q ^ key_q;
        count_d   = 2'd3;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      matrix3_q <= '0;
      key_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      matrix3_q <= matrix3_d;
      key_q     <= key_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end
  assign count   = count_q;
  assign matrix3 = matrix3_q;
  assign busy    = busy_q;
  assign done    = done_q;
endmodule

// File: tb/tb_aes_inv.sv
// tb_aes_inv: directed and round-trip checks of aes_inv, including drop, back-to-back and abort behaviour.
module tb_aes_inv;
  logic         clk = 0, rst = 1, valid = 0, last = 0;
  logic [127:0] matrix1 = '0, matrix2 = '0, matrix3;
  logic [1:0]   count;
  logic         busy, done;
  int           vecs = 0, errs = 0;

  aes_inv dut (
    .clk(clk), .rst(rst), .valid(valid),
`ifdef AES_INV_LAST_ROUND_EN
    .last(last),
`endif
    .matrix1(matrix1), .matrix2(matrix2),
    .count(count), .matrix3(matrix3), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] fwd_round(input logic [127:0] s, input logic [127:0] k);
    logic [127:0] x, y, z;
    logic [7:0] a0, a1, a2, a3;
    x = s ^ k;
    y = '0;
    z = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        y[127-8*(4*c+r) -: 8] = x[127-8*(4*((c+r)%4)+r) -: 8];
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = y[127-32*c -: 32];
      z[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return z;
  endfunction

  task automatic do_op(input logic [127:0] m1, input logic [127:0] k, input logic lst,
                       output logic [127:0] res, output logic [1:0] cnt, output logic dn);
    valid = 1; matrix1 = m1; matrix2 = k; last = lst;
    step();
    valid = 0; last = 0;
    step();
    step();
    res = matrix3; cnt = count; dn = done;
  endtask

  task automatic test_reset();
    rst = 1;
    step();
    step();
    vecs++;
    if (count !== 2'd0 || matrix3 !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL reset: count=%0d matrix3=%h busy=%b done=%b, want 0/0/0/0", count, matrix3, busy, done);
    end
    rst = 0;
    step();
  endtask

  task automatic test_inv_mix();
    logic [127:0] exp = {4{32'hdb135345}};
    valid = 1; matrix1 = {4{32'h8e4da1bc}}; matrix2 = '0;
    step();
    valid = 1; matrix1 = {4{32'h12345678}}; matrix2 = {4{32'hdeadbeef}};
    vecs++;
    if (count !== 2'd1 || matrix3 !== exp || busy !== 1'b1 || done !== 1'b0) begin
      errs++;
      $display("FAIL inv_mix stage1: count=%0d matrix3=%h busy=%b done=%b, want 1 %h 1 0", count, matrix3, busy, done, exp);
    end
    step();
    valid = 0;
    vecs++;
    if (count !== 2'd2 || matrix3 !== exp || done !== 1'b0) begin
      errs++;
      $display("FAIL inv_mix stage2: count=%0d matrix3=%h done=%b, want 2 %h 0", count, matrix3, done, exp);
    end
    step();
    vecs++;
    if (count !== 2'd3 || matrix3 !== exp || done !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL inv_mix stage3: count=%0d matrix3=%h done=%b busy=%b, want 3 %h 1 0", count, matrix3, done, busy, exp);
    end
    step();
    step();
    vecs++;
    if (count !== 2'd3 || matrix3 !== exp || done !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL idle_hold: count=%0d matrix3=%h done=%b busy=%b, want 3 %h 0 0", count, matrix3, done, busy, exp);
    end
  endtask

  task automatic test_key();
    logic [127:0] res;
    logic [1:0] cnt;
    logic dn;
    do_op({4{32'h9fdc589d}}, {4{32'hffffffff}}, 1'b0, res, cnt, dn);
    vecs++;
    if (res !== {4{32'h0df5dda3}} || cnt !== 2'd3 || dn !== 1'b1) begin
      errs++;
      $display("FAIL add_key: matrix3=%h count=%0d done=%b, want %h 3 1", res, cnt, dn, {4{32'h0df5dda3}});
    end
  endtask

  task automatic test_last();
    logic [127:0] exp = 128'h000d0a0704010e0b0805020f0c090603;
    valid = 1; last = 1; matrix1 = 128'h000102030405060708090a0b0c0d0e0f; matrix2 = '0;
    step();
    valid = 0; last = 0;
    step();
    vecs++;
    if (count !== 2'd2 || matrix3 !== exp) begin
      errs++;
      $display("FAIL last_shift: count=%0d matrix3=%h, want 2 %h", count, matrix3, exp);
    end
    step();
    vecs++;
    if (count !== 2'd3 || matrix3 !== exp || done !== 1'b1) begin
      errs++;
      $display("FAIL last_final: count=%0d matrix3=%h done=%b, want 3 %h 1", count, matrix3, done, exp);
    end
  endtask

  task automatic test_round_trip();
    logic [127:0] s, k, res;
    logic [1:0] cnt;
    logic dn;
    int bad = 0;
    for (int n = 0; n < 1000; n++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      do_op(fwd_round(s, k), k, 1'b0, res, cnt, dn);
      vecs++;
      if (res !== s || dn !== 1'b1) begin
        errs++;
        bad++;
        if (bad <= 5) $display("FAIL round_trip %0d: matrix3=%h done=%b, want %h 1", n, res, dn, s);
      end
    end
  endtask

  task automatic test_drop();
    logic [127:0] exp = {4{32'h0df5dda3}};
    int dones = 0;
    valid = 1; matrix1 = {4{32'h9fdc589d}}; matrix2 = {4{32'hffffffff}};
    step();
    matrix1 = {4{32'h8e4da1bc}}; matrix2 = '0;
    step();
    step();
    if (done) dones++;
    valid = 0;
    vecs++;
    if (matrix3 !== exp || count !== 2'd3) begin
      errs++;
      $display("FAIL drop_result: matrix3=%h count=%0d, want %h 3", matrix3, count, exp);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      if (done) dones++;
    end
    vecs++;
    if (dones !== 1 || count !== 2'd3 || busy !== 1'b0) begin
      errs++;
      $display("FAIL drop_done: dones=%0d count=%0d busy=%b, want 1 3 0", dones, count, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] res;
    logic [1:0] cnt;
    logic dn;
    do_op({4{32'h8e4da1bc}}, '0, 1'b0, res, cnt, dn);
    valid = 1; matrix1 = {4{32'h9fdc589d}}; matrix2 = {4{32'hffffffff}};
    step();
    valid = 0;
    vecs++;
    if (count !== 2'd1 || busy !== 1'b1 || dn !== 1'b1) begin
      errs++;
      $display("FAIL b2b_accept: count=%0d busy=%b prev_done=%b, want 1 1 1", count, busy, dn);
    end
    step();
    step();
    vecs++;
    if (matrix3 !== {4{32'h0df5dda3}} || done !== 1'b1) begin
      errs++;
      $display("FAIL b2b_result: matrix3=%h done=%b, want %h 1", matrix3, done, {4{32'h0df5dda3}});
    end
    step();
  endtask

  task automatic test_abort();
    logic [127:0] res;
    logic [1:0] cnt;
    logic dn;
    int dones = 0;
    valid = 1; matrix1 = {4{32'h9fdc589d}}; matrix2 = {4{32'hffffffff}};
    step();
    valid = 0;
    step();
    rst = 1; valid = 1;
    step();
    rst = 0; valid = 0;
    if (done) dones++;
    vecs++;
    if (count !== 2'd0 || matrix3 !== '0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL abort_state: count=%0d matrix3=%h busy=%b, want 0 0 0", count, matrix3, busy);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) dones++;
    end
    vecs++;
    if (dones !== 0 || count !== 2'd0) begin
      errs++;
      $display("FAIL abort_done: dones=%0d count=%0d, want 0 0", dones, count);
    end
    do_op({4{32'h8e4da1bc}}, '0, 1'b0, res, cnt, dn);
    vecs++;
    if (res !== {4{32'hdb135345}} || cnt !== 2'd3 || dn !== 1'b1) begin
      errs++;
      $display("FAIL abort_recover: matrix3=%h count=%0d done=%b, want %h 3 1", res, cnt, dn, {4{32'hdb135345}});
    end
  endtask

  initial begin
    test_reset();
    test_inv_mix();
    test_key();
`ifdef AES_INV_LAST_ROUND_EN
    test_last();
`endif
    test_drop();
    test_back_to_back();
    test_abort();
    test_round_trip();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
